// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_stage_ctrl_if                                         |
// | Brief    : Data-memory request/acknowledge bus for the MEM stage.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface mem_stage_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_rdata, dm_ack
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_rdata, dm_ack
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_stage_ctrl                                            |
// | Brief    : MEM-stage controller: multi-cycle data-memory access with |
// |            pipeline stall, branch resolution and MEM/WB register.    |
// |            Optional access timeout enabled by macro MEM_TIMEOUT_EN.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mem_stage_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  wire               clk,
   input  wire               rst,
   input  wire               mem_write,
   input  wire               mem_read,
   input  wire               branch,
   input  wire               zero,
   input  wire  [DATA_W-1:0] alu_result,
   input  wire  [DATA_W-1:0] store_data,
   input  wire  [ADDR_W-1:0] branch_target,
   mem_stage_ctrl_if.master  dm,
   output logic              stall,
   output logic              pc_src,
   output logic [ADDR_W-1:0] pc_branch,
   output logic [DATA_W-1:0] wb_alu,
   output logic [DATA_W-1:0] wb_rdata,
   output logic              wb_valid,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_dm_req;
   logic              r_dm_we;
   logic [ADDR_W-1:0] r_dm_addr;
   logic [DATA_W-1:0] r_dm_wdata;
   logic [DATA_W-1:0] r_rbuf;
   logic [DATA_W-1:0] r_wb_alu;
   logic [DATA_W-1:0] r_wb_rdata;
   logic              r_wb_valid;
   logic              w_access;
   logic              w_stall;

`ifdef MEM_TIMEOUT_EN
   localparam int              c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
   logic [c_CNT_W-1:0] r_to_cnt;
   logic               r_mem_err;
`endif

   assign w_access = mem_read | mem_write;
   // Gated by reset so the pipeline is not held frozen while in reset.
   assign w_stall  = rst & (((r_state == S_IDLE) & w_access) | (r_state == S_ACCESS));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_dm_req   <= 1'b0;
         r_dm_we    <= 1'b0;
         r_dm_addr  <= '0;
         r_dm_wdata <= '0;
         r_rbuf     <= '0;
         r_wb_alu   <= '0;
         r_wb_rdata <= '0;
         r_wb_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         r_to_cnt   <= '0;
         r_mem_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  r_dm_req   <= 1'b1;
                  r_dm_we    <= mem_write;
                  r_dm_addr  <= alu_result[ADDR_W-1:0];
                  r_dm_wdata <= store_data;
                  r_state    <= S_ACCESS;
`ifdef MEM_TIMEOUT_EN
                  r_to_cnt   <= '0;
`endif
               end
            end
            S_ACCESS: begin
               if (dm.dm_ack) begin
                  r_dm_req <= 1'b0;
                  if (!r_dm_we) begin
                     r_rbuf <= dm.dm_rdata;
                  end
                  r_state  <= S_DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (r_to_cnt == c_TO_LAST) begin
                  r_dm_req  <= 1'b0;
                  r_rbuf    <= '0;
                  r_mem_err <= 1'b1;
                  r_to_cnt  <= r_to_cnt + 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_to_cnt  <= r_to_cnt + 1'b1;
               end
`endif
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Only the DONE cycle of a read carries load data into writeback.
         if (!w_stall) begin
            r_wb_valid <= 1'b1;
            r_wb_alu   <= alu_result;
            r_wb_rdata <= ((r_state == S_DONE) && !r_dm_we) ? r_rbuf : '0;
         end else begin
            r_wb_valid <= 1'b0;
         end
      end
   end

   assign dm.dm_req   = r_dm_req;
   assign dm.dm_we    = r_dm_we;
   assign dm.dm_addr  = r_dm_addr;
   assign dm.dm_wdata = r_dm_wdata;

   assign stall     = w_stall;
   assign pc_src    = branch & zero & ~w_stall;
   assign pc_branch = branch_target;
   assign wb_alu    = r_wb_alu;
   assign wb_rdata  = r_wb_rdata;
   assign wb_valid  = r_wb_valid;

`ifdef MEM_TIMEOUT_EN
   assign mem_err = r_mem_err;
`else
   assign mem_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// Bench for mem_stage_ctrl: transaction-level expectation model plus a
// per-cycle compare process and literal checks from the test plan.
module tb_mem_stage_ctrl;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_write = 1'b0, mem_read = 1'b0, branch = 1'b0, zero = 1'b0;
   logic [31:0] alu_result = '0, store_data = '0, branch_target = '0;
   logic [31:0] bus_rdata = '0;
   logic        bus_ack = 1'b0;
   logic        stall, pc_src, wb_valid, mem_err;
   logic [31:0] pc_branch, wb_alu, wb_rdata;

   int checks = 0;
   int failures = 0;
   int n_stall = 0;
   int n_req = 0;

   // expected values for the cycle in progress
   logic        exp_chk = 1'b0;
   logic        exp_stall, exp_req, exp_we, exp_pc_src, exp_wb_valid, exp_err;
   logic [31:0] exp_addr, exp_wdata, exp_wb_alu, exp_wb_rdata;

   // MEM/WB contents the spec says must be present
   logic        m_wb_valid = 1'b0;
   logic [31:0] m_wb_alu = '0, m_wb_rdata = '0;
   logic        m_err = 1'b0;

   always #5 clk = ~clk;

   mem_stage_ctrl_if #(.DATA_W(32), .ADDR_W(32)) dm_bus ();
   assign dm_bus.dm_rdata = bus_rdata;
   assign dm_bus.dm_ack   = bus_ack;

   mem_stage_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_write(mem_write), .mem_read(mem_read), .branch(branch), .zero(zero),
      .alu_result(alu_result), .store_data(store_data), .branch_target(branch_target),
      .dm(dm_bus),
      .stall(stall), .pc_src(pc_src), .pc_branch(pc_branch),
      .wb_alu(wb_alu), .wb_rdata(wb_rdata), .wb_valid(wb_valid), .mem_err(mem_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (stall) n_stall++;
         if (dm_bus.dm_req) n_req++;
      end
      if (exp_chk) begin
         chk("stall", stall, exp_stall);
         chk("dm_req", dm_bus.dm_req, exp_req);
         chk("pc_src", pc_src, exp_pc_src);
         chk("pc_branch", pc_branch, branch_target);
         chk("wb_valid", wb_valid, exp_wb_valid);
         chk("wb_alu", wb_alu, exp_wb_alu);
         chk("wb_rdata", wb_rdata, exp_wb_rdata);
         chk("mem_err", mem_err, exp_err);
         if (exp_req) begin
            chk("dm_we", dm_bus.dm_we, exp_we);
            chk("dm_addr", dm_bus.dm_addr, exp_addr);
            chk("dm_wdata", dm_bus.dm_wdata, exp_wdata);
         end
      end
   end

   // One pipeline cycle; wbr is the load data writeback receives if it advances.
   task automatic step(input logic st, input logic req, input logic [31:0] wbr);
      exp_stall    = st;
      exp_req      = req;
      exp_pc_src   = branch & zero & ~st;
      exp_wb_valid = m_wb_valid;
      exp_wb_alu   = m_wb_alu;
      exp_wb_rdata = m_wb_rdata;
      exp_err      = m_err;
      exp_chk      = 1'b1;
      @(posedge clk);
      if (!st) begin
         m_wb_valid = 1'b1;
         m_wb_alu   = alu_result;
         m_wb_rdata = wbr;
      end else begin
         m_wb_valid = 1'b0;
      end
      #1;
   endtask

   // delay = ACCESS cycle carrying the ack; tmo = never ack, expect abort.
   task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int delay, input bit tmo);
      int n;
      mem_read = rd; mem_write = wr; alu_result = addr; store_data = wdata;
      branch = 1'b0; zero = 1'b0;
      exp_we = wr; exp_addr = addr; exp_wdata = wdata;
      step(1'b1, 1'b0, '0);
      n = tmo ? TO : delay;
      for (int k = 1; k <= n; k++) begin
         bus_ack   = !tmo && (k == delay);
         bus_rdata = (k == delay) ? rdata : 32'hBAD0_0000 + k;
         step(1'b1, 1'b1, '0);
      end
      bus_ack = 1'b0;
      if (tmo) m_err = 1'b1;
      step(1'b0, 1'b0, (wr || tmo) ? 32'h0 : rdata);
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic alu_op(input logic [31:0] res, input logic br, input logic z,
                         input logic [31:0] tgt);
      alu_result = res; branch = br; zero = z; branch_target = tgt;
      mem_read = 1'b0; mem_write = 1'b0;
      step(1'b0, 1'b0, '0);
   endtask

   int s0, r0;

   initial begin
      exp_stall = 0; exp_req = 0; exp_we = 0; exp_pc_src = 0; exp_wb_valid = 0;
      exp_err = 0; exp_addr = 0; exp_wdata = 0; exp_wb_alu = 0; exp_wb_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dm_req", dm_bus.dm_req, 0);
      chk("rst_dm_addr", dm_bus.dm_addr, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_alu", wb_alu, 0);
      chk("rst_stall", stall, 0);
      chk("rst_mem_err", mem_err, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // load, ack on the first ACCESS cycle
      s0 = n_stall; r0 = n_req;
      mem_op(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1, 1'b0);
      chk("load_stall_cycles", n_stall - s0, 2);
      chk("load_req_cycles", n_req - r0, 1);
      chk("load_wb_rdata", wb_rdata, 32'hDEADBEEF);
      chk("load_wb_valid", wb_valid, 1);
      alu_op(32'h7, 1'b0, 1'b0, 32'h0);

      // store, ack after four ACCESS cycles
      s0 = n_stall; r0 = n_req;
      mem_op(1'b0, 1'b1, 32'h44, 32'h12345678, 32'hCAFEF00D, 4, 1'b0);
      chk("store_stall_cycles", n_stall - s0, 5);
      chk("store_req_cycles", n_req - r0, 4);
      chk("store_wb_rdata", wb_rdata, 32'h0);

      // branch taken / not taken
      alu_result = 32'h55; branch = 1'b1; zero = 1'b1; branch_target = 32'h100;
      #1;
      chk("br_pc_src", pc_src, 1);
      chk("br_pc_branch", pc_branch, 32'h100);
      chk("br_stall", stall, 0);
      step(1'b0, 1'b0, '0);
      zero = 1'b0; #1;
      chk("br_nt_pc_src", pc_src, 0);
      step(1'b0, 1'b0, '0);
      alu_op(32'h9, 1'b1, 1'b1, 32'h200);
      branch = 1'b0;

      // both controls set: write wins
      mem_op(1'b1, 1'b1, 32'h48, 32'hA5A5A5A5, 32'h11111111, 2, 1'b0);
      chk("rw_dm_we", dm_bus.dm_we, 1);
      chk("rw_wb_rdata", wb_rdata, 32'h0);

      // reset in the 2nd ACCESS cycle
      mem_read = 1'b1; alu_result = 32'h80; exp_we = 1'b0; exp_addr = 32'h80;
      exp_wdata = store_data;
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, '0);
      exp_chk = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rstmid_dm_req", dm_bus.dm_req, 0);
      chk("rstmid_stall", stall, 0);
      chk("rstmid_wb_valid", wb_valid, 0);
      m_wb_valid = 1'b0; m_wb_alu = '0; m_wb_rdata = '0; m_err = 1'b0;
      mem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      bus_ack = 1'b1; bus_rdata = 32'h99999999;
      alu_op(32'h3, 1'b0, 1'b0, 32'h0);
      bus_ack = 1'b0;
      alu_op(32'h4, 1'b0, 1'b0, 32'h0);
      chk("late_ack_req", dm_bus.dm_req, 0);
      mem_op(1'b1, 1'b0, 32'h84, 32'h0, 32'h0BADCAFE, 3, 1'b0);
      chk("post_rst_load", wb_rdata, 32'h0BADCAFE);

`ifdef MEM_TIMEOUT_EN
      s0 = n_req;
      mem_op(1'b1, 1'b0, 32'h90, 32'h0, 32'h0, 0, 1'b1);
      chk("tmo_req_cycles", n_req - s0, TO);
      chk("tmo_mem_err", mem_err, 1);
      chk("tmo_wb_rdata", wb_rdata, 32'h0);
      alu_op(32'h5, 1'b0, 1'b0, 32'h0);
      mem_op(1'b1, 1'b0, 32'h94, 32'h0, 32'h77777777, 1, 1'b0);
      chk("tmo_sticky", mem_err, 1);
      chk("tmo_resume", wb_rdata, 32'h77777777);
`endif

      alu_op(32'h6, 1'b0, 1'b0, 32'h0);
      exp_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
